// File: rtl/chase_pkg.sv
// chase_pkg: shared states, error codes and direction constants for the LED chase decoder.
package chase_pkg;
  typedef enum logic [2:0] {IDLE, ACQ, UP, DOWN, FAULT} state_t;
  typedef logic [1:0] err_code_t;
  localparam err_code_t ERR_NONE   = 2'b00;
  localparam err_code_t ERR_ONEHOT = 2'b01;
  localparam err_code_t ERR_JUMP   = 2'b10;
  localparam err_code_t ERR_REV    = 2'b11;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/chase_decoder_if.sv
// chase_decoder_if: sample inputs and tracking outputs of the chase decoder.
interface chase_decoder_if #(
  parameter int N_LEDS = 8,
  parameter int CNT_W  = 16,
  parameter int POS_W  = $clog2(N_LEDS)
);
  logic              SAMPLE_EN;
  logic              CLR_ERR;
  logic [N_LEDS-1:0] LED_IN;
  logic [POS_W-1:0]  POS;
  logic              DIR;
  logic              VALID;
  logic              ERR;
  logic [1:0]        ERR_CODE;
  logic [CNT_W-1:0]  STEP_CNT;
  logic [CNT_W-1:0]  LAP_CNT;
  modport master (
    output SAMPLE_EN, CLR_ERR, LED_IN,
    input  POS, DIR, VALID, ERR, ERR_CODE, STEP_CNT, LAP_CNT
  );
  modport slave (
    input  SAMPLE_EN, CLR_ERR, LED_IN,
    output POS, DIR, VALID, ERR, ERR_CODE, STEP_CNT, LAP_CNT
  );
endinterface

// File: rtl/onehot_enc.sv
// onehot_enc: index of the set bit of an N-bit vector plus an exactly-one-bit-set flag.
module onehot_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         onehot_o
);
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) idx_o = vec_i[i] ? idx_o | W'(i) : idx_o;
  end
  assign onehot_o = (vec_i != '0) && ((vec_i & (vec_i - 1'b1)) == '0);
endmodule

// File: rtl/chase_decoder.sv
// chase_decoder: tracks a bouncing one-hot LED pattern, flags illegal moves, counts steps and laps.
module chase_decoder
  import chase_pkg::*;
#(
  parameter int N_LEDS = 8,
  parameter int CNT_W  = 16,
  parameter int POS_W  = $clog2(N_LEDS)
) (
  input logic CLK,
  input logic RST,
  chase_decoder_if.slave bus
);
  state_t           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d, idx;
  logic             dir_q, dir_d, onehot;
  err_code_t        code_q, code_d;
  logic [CNT_W-1:0] step_q, step_d, lap_q, lap_d;
  int               n, p;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
  onehot_enc #(.N(N_LEDS), .W(POS_W)) u_enc (
    .vec_i   (bus.LED_IN),
    .idx_o   (idx),
    .onehot_o(onehot)
  );
  assign n = int'(idx);
  assign p = int'(pos_q);
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    code_d  = code_q;
    step_d  = step_q;
    lap_d   = lap_q;
    if (bus.CLR_ERR) begin
      state_d = IDLE;
      code_d  = ERR_NONE;
    end else if (bus.SAMPLE_EN && state_q != FAULT) begin
      if (!onehot) begin
        state_d = state_q == IDLE ? IDLE : FAULT;
        code_d  = state_q == IDLE ? code_q : ERR_ONEHOT;
      end else begin
        case (state_q)
          IDLE: begin
            pos_d   = idx;
            state_d = n == 0 ? UP : n == N_LEDS - 1 ? DOWN : ACQ;
            dir_d   = n == N_LEDS - 1 && n != 0 ? DIR_DOWN : DIR_UP;
          end
          ACQ: begin
            if (n == p + 1 || n == p - 1) begin
              state_d = n == p + 1 ? UP : DOWN;
              dir_d   = n == p + 1 ? DIR_UP : DIR_DOWN;
              pos_d   = idx;
              step_d  = sat_inc(step_q);
            end else if (n != p) begin
              state_d = FAULT;
              code_d  = ERR_JUMP;
            end
          end
          UP: begin
            if (n == p) begin
              state_d = UP;
            end else if ((p < N_LEDS - 1 && n == p + 1) || (p == N_LEDS - 1 && n == N_LEDS - 2)) begin
              state_d = p == N_LEDS - 1 ? DOWN : UP;
              dir_d   = p == N_LEDS - 1 ? DIR_DOWN : DIR_UP;
              pos_d   = idx;
              step_d  = sat_inc(step_q);
            end else begin
              state_d = FAULT;
              code_d  = p < N_LEDS - 1 && n == p - 1 ? ERR_REV : ERR_JUMP;
            end
          end
          DOWN: begin
            if (n == p) begin
              state_d = DOWN;
            end else if ((p > 0 && n == p - 1) || (p == 0 && n == 1)) begin
              state_d = p == 0 ? UP : DOWN;
              dir_d   = p == 0 ? DIR_UP : DIR_DOWN;
              pos_d   = idx;
              step_d  = sat_inc(step_q);
              lap_d   = p == 0 ? sat_inc(lap_q) : lap_q;
            end else begin
              state_d = FAULT;
              code_d  = p > 0 && n == p + 1 ? ERR_REV : ERR_JUMP;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pos_q   <= '0;
      dir_q   <= DIR_UP;
      code_q  <= ERR_NONE;
      step_q  <= '0;
      lap_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      code_q  <= code_d;
      step_q  <= step_d;
      lap_q   <= lap_d;
    end
  end
  assign bus.POS      = pos_q;
  assign bus.DIR      = dir_q;
  assign bus.VALID    = state_q == UP || state_q == DOWN;
  assign bus.ERR      = state_q == FAULT;
  assign bus.ERR_CODE = code_q;
  assign bus.STEP_CNT = step_q;
  assign bus.LAP_CNT  = lap_q;
endmodule

// File: tb/tb_chase_decoder.sv
// tb_chase_decoder: directed vector table on an 8-LED decoder plus a 4-bit counter saturation run.
module tb_chase_decoder;
  typedef struct {
    logic       rst, en, clr;
    logic [7:0] led;
    logic [2:0] pos;
    logic       dir, valid, err;
    logic [1:0] code;
    logic [15:0] step, lap;
  } vec_t;
  logic CLK = 1'b0;
  logic rst8, rst4;
  int n_chk = 0;
  int n_fail = 0;
  vec_t vecs[$];
  chase_decoder_if #(.N_LEDS(8), .CNT_W(16)) bus8 ();
  chase_decoder_if #(.N_LEDS(8), .CNT_W(4))  bus4 ();
  chase_decoder #(.N_LEDS(8), .CNT_W(16)) dut8 (.CLK(CLK), .RST(rst8), .bus(bus8));
  chase_decoder #(.N_LEDS(8), .CNT_W(4))  dut4 (.CLK(CLK), .RST(rst4), .bus(bus4));
  always #5 CLK = ~CLK;
  task automatic add(input logic rst, en, clr, input logic [7:0] led, input logic [2:0] pos,
                     input logic dir, valid, err, input logic [1:0] code, input logic [15:0] step, lap);
    vec_t v;
    v.rst = rst; v.en = en; v.clr = clr; v.led = led; v.pos = pos; v.dir = dir;
    v.valid = valid; v.err = err; v.code = code; v.step = step; v.lap = lap;
    vecs.push_back(v);
  endtask
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic track_prefix();
    add(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 8'h01, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 8'h02, 1, 0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 8'h04, 2, 0, 1, 0, 0, 2, 0);
    add(0, 1, 0, 8'h08, 3, 0, 1, 0, 0, 3, 0);
  endtask
  initial begin
    int p, d;
    rst8 = 1'b1; rst4 = 1'b1;
    bus8.SAMPLE_EN = 1'b0; bus8.CLR_ERR = 1'b0; bus8.LED_IN = '0;
    bus4.SAMPLE_EN = 1'b0; bus4.CLR_ERR = 1'b0; bus4.LED_IN = '0;
    // full bounce 0..7..0,1
    add(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      p = k <= 7 ? k : (k <= 14 ? 14 - k : 1);
      d = (k >= 8 && k <= 14) ? 1 : 0;
      add(0, 1, 0, 8'd1 << p, 3'(p), d[0], 1, 0, 0, 16'(k), k == 15 ? 16'd1 : 16'd0);
    end
    add(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 8'h08, 3, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 8'h10, 4, 0, 1, 0, 0, 1, 0);
    add(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 8'h04, 2, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 8'hff, 2, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 8'h04, 2, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 8'h01, 2, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 8'h04, 2, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 8'h03, 0, 0, 0, 0, 0, 0, 0);
    track_prefix();
    add(0, 1, 0, 8'h18, 3, 0, 0, 1, 1, 3, 0);
    add(0, 1, 0, 8'h01, 3, 0, 0, 1, 1, 3, 0);
    add(0, 0, 1, 8'h00, 3, 0, 0, 0, 0, 3, 0);
    track_prefix();
    add(0, 1, 0, 8'h04, 3, 0, 0, 1, 3, 3, 0);
    add(0, 1, 1, 8'h01, 3, 0, 0, 0, 0, 3, 0);
    add(0, 1, 0, 8'h01, 0, 0, 1, 0, 0, 3, 0);
    add(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 8'h01, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 8'h08, 0, 0, 0, 1, 2, 0, 0);
    add(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 8'h80, 7, 1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 8'h40, 6, 1, 1, 0, 0, 1, 0);
    add(0, 1, 0, 8'h80, 6, 1, 0, 1, 3, 1, 0);
    add(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 8'h08, 3, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 8'h40, 3, 0, 0, 1, 2, 0, 0);
    foreach (vecs[i]) begin
      @(negedge CLK);
      rst8 = vecs[i].rst; bus8.SAMPLE_EN = vecs[i].en; bus8.CLR_ERR = vecs[i].clr; bus8.LED_IN = vecs[i].led;
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d pos", i), 16'(bus8.POS), 16'(vecs[i].pos));
      chk($sformatf("v%0d dir", i), 16'(bus8.DIR), 16'(vecs[i].dir));
      chk($sformatf("v%0d valid", i), 16'(bus8.VALID), 16'(vecs[i].valid));
      chk($sformatf("v%0d err", i), 16'(bus8.ERR), 16'(vecs[i].err));
      chk($sformatf("v%0d code", i), 16'(bus8.ERR_CODE), 16'(vecs[i].code));
      chk($sformatf("v%0d step", i), bus8.STEP_CNT, vecs[i].step);
      chk($sformatf("v%0d lap", i), bus8.LAP_CNT, vecs[i].lap);
    end
    // 4-bit counters: 20 legal steps must stick at 15
    @(negedge CLK);
    rst4 = 1'b1;
    @(negedge CLK);
    rst4 = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      p = k <= 7 ? k : (k <= 14 ? 14 - k : k - 14);
      @(negedge CLK);
      bus4.SAMPLE_EN = 1'b1; bus4.LED_IN = 8'd1 << p;
      @(posedge CLK);
      #1;
      chk($sformatf("sat k%0d step", k), 16'(bus4.STEP_CNT), k > 15 ? 16'd15 : 16'(k));
      chk($sformatf("sat k%0d pos", k), 16'(bus4.POS), 16'(p));
    end
    chk("sat lap", 16'(bus4.LAP_CNT), 16'd1);
    chk("sat valid", 16'(bus4.VALID), 16'd1);
    @(negedge CLK);
    rst4 = 1'b1; bus4.LED_IN = 8'h80;
    @(posedge CLK);
    #1;
    chk("rst pos", 16'(bus4.POS), 16'd0);
    chk("rst dir", 16'(bus4.DIR), 16'd0);
    chk("rst valid", 16'(bus4.VALID), 16'd0);
    chk("rst err", 16'(bus4.ERR), 16'd0);
    chk("rst code", 16'(bus4.ERR_CODE), 16'd0);
    chk("rst step", 16'(bus4.STEP_CNT), 16'd0);
    chk("rst lap", 16'(bus4.LAP_CNT), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/chase_decoder.md
Name: chase_decoder

Overview:
- Receiving end of the LED chaser output bus: samples a one-hot N-LED pattern that bounces end to end, and recovers position and direction.
- Checks every observed move against the bounce sequence; counts legal steps and completed laps.
- Used as an on-board monitor and self-check for the chaser, either alongside it on LEDG or fed from switches.

Parameters:
- N_LEDS, 8, number of LEDs in the bar; legal range 2..16.
- POS_W, $clog2(N_LEDS), width of the position index.
- CNT_W, 16, width of the step and lap counters.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- SAMPLE_EN  in  1  strobe; LED_IN is evaluated only on edges where this is 1.
- CLR_ERR  in  1  synchronous clear of the fault state, back to IDLE.
- LED_IN  in  N_LEDS  observed LED pattern; bit 0 is the start end.
- POS  out  POS_W  index of the lit LED from the last accepted sample.
- DIR  out  1  0 = moving toward bit N-1, 1 = moving toward bit 0.
- VALID  out  1  1 when tracking is locked (states UP and DOWN).
- ERR  out  1  sticky fault flag.
- ERR_CODE  out  2  00 none, 01 not one-hot, 10 jump, 11 reversal away from an end.
- STEP_CNT  out  CNT_W  legal moves seen; saturates at all-ones.
- LAP_CNT  out  CNT_W  completed round trips; saturates at all-ones.

Behaviour:
- Reset: RST=1 at an edge sets state IDLE and all outputs to 0, counters included. RST overrides every other input.
- All outputs are registered. A sample taken at edge k appears on the outputs after edge k, so latency is 1 cycle.
- On edges with SAMPLE_EN=0, state and outputs hold.
- Let p = previous POS and n = index of the set bit.
- One-hot check: a sample with zero or two or more bits set is invalid.
  - Any non-IDLE state: go to FAULT with ERR_CODE=01.
  - IDLE: sample is ignored; no error.
- FSM states: IDLE, ACQ, UP, DOWN, FAULT.
- IDLE, on a valid sample:
  - Load POS=n.
  - n=0 goes to UP (DIR=0); n=N-1 goes to DOWN (DIR=1); otherwise go to ACQ.
- ACQ, on a valid sample:
  - n=p: hold.
  - n=p+1: UP, DIR=0.
  - n=p-1: DOWN, DIR=1.
  - Anything else: FAULT, ERR_CODE=10.
  - The acquiring move counts as a step.
- UP:
  - n=p: stall, legal, no count. The chaser may pause.
  - p<N-1 and n=p+1: legal step, stay in UP.
  - p=N-1 and n=N-2: legal bounce; go to DOWN, DIR=1, step counted.
  - p<N-1 and n=p-1: FAULT with ERR_CODE=11.
  - Any other n: FAULT with ERR_CODE=10.
- DOWN: mirror of UP.
  - The bounce at p=0 to n=1 goes to UP and also increments LAP_CNT.
  - Reversal away from an end gives ERR_CODE=11.
- FAULT:
  - ERR=1 and VALID=0; POS, DIR and counters freeze.
  - Samples are ignored. Only CLR_ERR or RST leaves FAULT.
- CLR_ERR=1, from any state: go to IDLE, ERR=0, ERR_CODE=00, VALID=0. Counters are kept, not cleared.
  - If SAMPLE_EN=1 on the same edge, CLR_ERR wins and the sample is discarded.
- VALID is 1 in UP and DOWN only.
- Counters are unsigned, increment by 1, and stick at 2^CNT_W-1.
- N_LEDS=2: positions 0 and 1 only; each legal move is a bounce. A lap is counted on each 0-to-1 transition out of DOWN.

Decomposition:
- Shared package chase_pkg holds:
  - The state enum {IDLE, ACQ, UP, DOWN, FAULT}.
  - ERR_CODE constants ERR_NONE, ERR_ONEHOT, ERR_JUMP, ERR_REV.
  - The DIR constants.
- One combinational sub-module, onehot_enc: N_LEDS-bit input to POS_W index plus an is_onehot flag. It is reusable by other LED blocks.
- FSM, counters and output registers stay in chase_decoder.

Test Plan:
- Chaser sequence 0,1,...,7,6,...,0,1 with SAMPLE_EN every cycle, N=8:
  - VALID=1 from the first sample.
  - STEP_CNT=15, LAP_CNT=1, no ERR.
  - DIR toggles on the edge after samples 8'h80 and 8'h01.
- Start mid-bar at 8'h08 then 8'h10: ACQ then UP, POS=4, DIR=0, STEP_CNT=1.
- Repeat 8'h04 three times with gaps of SAMPLE_EN=0: POS holds at 2, STEP_CNT unchanged, ERR=0.
- While tracking UP at POS=3, feed 8'h18: ERR=1, ERR_CODE=01, VALID=0. Then feed 8'h01: no change.
- Tracking UP at POS=3, feed 8'h04: ERR_CODE=11. Then CLR_ERR with SAMPLE_EN on the same edge: state IDLE, ERR=0, counters retained, sample ignored.
- Counter saturation with CNT_W=4: run 20 legal steps; STEP_CNT stays at 15. Assert RST mid-sequence: all outputs 0 on the next edge.
